prefetch_buffer: RTL and testbench

Instruction prefetch queue between the instruction fetch unit's `c2c_r` master port and instruction memory. It streams sequential aligned words from memory into a small circular buffer ahead of the program counter. It answers fetch requests from buffered words, including 2-byte-aligned requests that span two words, which compressed-instruction fetch produces. Any request outside the buffered window redirects the stream to the new address.

---
 rtl/prefetch_buffer_pkg.sv | 13 +
 rtl/c2c_r.sv | 12 +
 rtl/prefetch_buffer.sv | 94 +++++++++
 tb/tb_prefetch_buffer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prefetch_buffer_pkg.sv
// Shared constants and helpers for the instruction prefetch buffer.
// Instantiations take PREFETCH_DEPTH as the buffer depth.
package prefetch_buffer_pkg;

    localparam int         PREFETCH_DEPTH = 4;
    localparam logic [3:0] FULL_WORD_SEL  = 4'b1111;

    // A 2-byte-aligned fetch takes the upper half of the low word and the lower half of the next.
    function automatic logic [31:0] span_word(input logic [31:0] lo, input logic [31:0] hi);
        return {hi[15:0], lo[31:16]};
    endfunction

endpackage

// File: rtl/c2c_r.sv
// Read-only core-to-cache style bus: the master drives address, byte select and read enable,
// the slave answers with data and a same-cycle acknowledge.
interface c2c_r;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic        re;
    logic [31:0] data;
    logic        ack;

    modport master (output addr, sel, re, input data, ack);
    modport slave  (input addr, sel, re, output data, ack);
endinterface

// File: rtl/prefetch_buffer.sv
// Instruction prefetch queue: streams sequential words into a circular buffer ahead of the PC
// and answers aligned and half-word-spanning fetches from it, redirecting on any out-of-window request.
module prefetch_buffer
    import prefetch_buffer_pkg::*;
#(
    parameter int          DEPTH    = PREFETCH_DEPTH,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic  clk,
    input logic  reset_n,
    c2c_r.slave  core_bus,
    c2c_r.master mem_bus
);

    localparam int            PW   = $clog2(DEPTH);
    localparam int            CW   = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [29:0]   head_word;
    logic [29:0]   fetch_word;
    logic [CW-1:0] count;
    logic [PW-1:0] rp;
    logic [31:0]   entries [DEPTH];

    logic [29:0]   req_word;
    logic [29:0]   off;
    logic          base_k0;
    logic          base_k1;
    logic          redirect;
    logic          pop;
    logic          push;
    logic          hit;
    logic          mem_re;
    logic [CW-1:0] need;
    logic [PW-1:0] slot_lo;
    logic [PW-1:0] slot_hi;
    logic [PW-1:0] slot_wr;

    // Window selection: the request may sit on the head word or one past it; anything else redirects.
    always_comb begin
        req_word = core_bus.addr[31:2];
        off      = req_word - head_word;
        base_k0  = (off == 30'd0);
        base_k1  = (off == 30'd1) && (count != '0);
        redirect = core_bus.re && !base_k0 && !base_k1;
        pop      = core_bus.re && base_k1;
        need     = CW'(base_k1) + CW'(core_bus.addr[1]);
        hit      = core_bus.re && !redirect && (count > need);
        slot_lo  = rp + PW'(base_k1);
        slot_hi  = slot_lo + PW'(1);
        mem_re   = (count != FULL);
        push     = mem_re && mem_bus.ack && !redirect;
        slot_wr  = rp + count[PW-1:0];
    end

    always_comb begin
        core_bus.ack  = hit;
        core_bus.data = core_bus.addr[1] ? span_word(entries[slot_lo], entries[slot_hi])
                                         : entries[slot_lo];
        mem_bus.addr  = {fetch_word, 2'b00};
        mem_bus.sel   = FULL_WORD_SEL;
        mem_bus.re    = mem_re;
    end

    // A redirect empties the window; data acked in that same cycle belongs to the old stream.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_word  <= RESET_PC[31:2];
            fetch_word <= RESET_PC[31:2];
            count      <= '0;
            rp         <= '0;
        end else if (redirect) begin
            head_word  <= req_word;
            fetch_word <= req_word;
            count      <= '0;
        end else begin
            if (pop) begin
                head_word <= head_word + 30'd1;
                rp        <= rp + PW'(1);
            end
            if (push) begin
                fetch_word <= fetch_word + 30'd1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            entries[slot_wr] <= mem_bus.data;
        end
    end

endmodule

// File: tb/tb_prefetch_buffer.sv
// Scoreboard bench for prefetch_buffer: a queue-based window model predicts core acks,
// a separate monitor compares them with what the buffer presents.
module tb_prefetch_buffer;
    import prefetch_buffer_pkg::*;

    localparam int          DEPTH    = PREFETCH_DEPTH;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic [31:0] addr;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    c2c_r core_if ();
    c2c_r mem_if ();

    prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .core_bus(core_if),
        .mem_bus (mem_if)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    exp_t        sb[$];
    logic [31:0] mq[$];
    logic [29:0] m_head;
    logic [29:0] m_fetch;
    logic        exp_redirect;
    logic        exp_pop;
    logic        exp_push;
    logic [29:0] exp_target;
    logic [31:0] cur_addr;

    function automatic logic [31:0] mem_word(input logic [29:0] w);
        return ({2'b00, w} * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, actual, expected);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        sb.delete();
        m_head  = RESET_PC[31:2];
        m_fetch = RESET_PC[31:2];
    endtask

    // Window model: entries are the words from m_head onward, held in a plain queue.
    task automatic predict(input logic re, input logic [31:0] addr);
        logic [29:0] off;
        logic [31:0] w0;
        logic [31:0] w1;
        exp_t        e;
        int          k;
        int          need;
        off          = addr[31:2] - m_head;
        exp_redirect = 1'b0;
        exp_pop      = 1'b0;
        exp_target   = addr[31:2];
        k            = 0;
        if (re) begin
            if (off == 30'd0) begin
                k = 0;
            end else if (off == 30'd1 && mq.size() >= 1) begin
                k       = 1;
                exp_pop = 1'b1;
            end else begin
                exp_redirect = 1'b1;
            end
            if (!exp_redirect) begin
                need = k + 1 + int'(addr[1]);
                if (mq.size() >= need) begin
                    w0     = mq[k];
                    w1     = (addr[1]) ? mq[k+1] : 32'h0;
                    e.cyc  = cyc;
                    e.addr = addr;
                    e.data = addr[1] ? {w1[15:0], w0[31:16]} : w0;
                    sb.push_back(e);
                end
            end
        end
        exp_push = mem_if.ack && (mq.size() < DEPTH) && !exp_redirect;
    endtask

    task automatic updateModel();
        if (exp_redirect) begin
            mq.delete();
            m_head  = exp_target;
            m_fetch = exp_target;
        end else begin
            if (exp_pop) begin
                void'(mq.pop_front());
                m_head++;
            end
            if (exp_push) begin
                mq.push_back(mem_word(m_fetch));
                m_fetch++;
            end
        end
    endtask

    task automatic applyStimulus(input logic re, input logic [31:0] addr, input bit ack_en);
        @(negedge clk);
        cyc++;
        core_if.re   = re;
        core_if.addr = addr;
        mem_if.ack   = ack_en && mem_if.re;
        mem_if.data  = mem_word(mem_if.addr[31:2]);
        #1;
        checkOutput("mem_re", {31'd0, mem_if.re}, {31'd0, (mq.size() < DEPTH)});
        checkOutput("mem_addr", mem_if.addr, {m_fetch, 2'b00});
        predict(re, addr);
        @(posedge clk);
        updateModel();
    endtask

    // Asynchronous reset asserted mid-cycle with a memory ack pending; outputs must clear at once.
    task automatic doReset();
        #2;
        mem_if.ack  = 1'b1;
        mem_if.data = 32'hDEAD_BEEF;
        reset_n     = 1'b0;
        #1;
        checkOutput("reset_core_ack", {31'd0, core_if.ack}, 32'd0);
        checkOutput("reset_mem_re", {31'd0, mem_if.re}, 32'd1);
        checkOutput("reset_mem_addr", mem_if.addr, RESET_PC);
        modelReset();
        @(negedge clk);
        mem_if.ack = 1'b0;
        core_if.re = 1'b0;
        reset_n    = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        logic exp_ack;
        forever begin
            @(negedge clk);
            #2;
            exp_ack = (sb.size() > 0) && (sb[0].cyc == cyc);
            checkOutput("core_ack", {31'd0, core_if.ack}, {31'd0, exp_ack});
            if (exp_ack) begin
                e = sb.pop_front();
                if (core_if.ack === 1'b1) begin
                    checkOutput("core_data", core_if.data, e.data);
                end
            end
        end
    end

    initial begin : stimulus
        int r;
        core_if.re   = 1'b0;
        core_if.addr = 32'h0;
        core_if.sel  = 4'hF;
        mem_if.ack   = 1'b0;
        mem_if.data  = 32'h0;
        exp_redirect = 1'b0;
        exp_pop      = 1'b0;
        exp_push     = 1'b0;
        exp_target   = '0;
        doReset();

        // Sequential stream with zero-wait memory, then hold until the buffer fills.
        applyStimulus(1'b1, 32'h0, 1'b1);
        applyStimulus(1'b1, 32'h0, 1'b1);
        applyStimulus(1'b1, 32'h4, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 32'h8, 1'b1);

        // Redirect to 0x100, let it fill, then redirect far away.
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 32'h100, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h800, 1'b1);

        // Redirect while fills are still landing.
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 32'h100, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h400, 1'b1);

        // Spanning fetch that must wait for the second word.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h202, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h202, 1'b1);

        // Compressed stepping: 0x200, 0x202, 0x206 pops the head.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h206, 1'b1);
        applyStimulus(1'b1, 32'h20A, 1'b1);
        applyStimulus(1'b1, 32'h20C, 1'b1);

        // Reset with two words buffered and a hit in progress.
        doReset();
        applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 32'h0, 1'b0);
        core_if.re   = 1'b1;
        core_if.addr = 32'h0;
        doReset();

        // Random walk: stalls, half-word and word steps, misaligned bytes, jumps, wrap-around.
        cur_addr = 32'h0;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 30) begin
                cur_addr = cur_addr;
            end else if (r < 55) begin
                cur_addr = cur_addr + 32'd2;
            end else if (r < 75) begin
                cur_addr = cur_addr + 32'd4;
            end else if (r < 79) begin
                cur_addr = cur_addr + 32'd6;
            end else if (r < 84) begin
                cur_addr = {$urandom} & 32'hFFFF_FFFE;
            end else if (r < 87) begin
                cur_addr = 32'hFFFF_FFF0 + ($urandom_range(0, 7) * 2);
            end else if (r < 92) begin
                cur_addr = cur_addr | 32'd1;
            end else begin
                cur_addr = cur_addr & 32'hFFFF_FFFE;
            end
            applyStimulus(($urandom_range(0, 9) != 0), cur_addr, ($urandom_range(0, 3) != 0));
        end

        @(negedge clk);
        #3;
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
